oob_detect: RTL and testbench

OOB_DETECT -- requirements
Module: oob_detect

---
 rtl/oob_pkg.sv | 34 +++
 rtl/oob_sat_counter.sv | 23 ++
 rtl/oob_detect.sv | 152 +++++++++++++++
 tb/tb_oob_detect.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/oob_pkg.sv
// Shared types and default timing for the SATA OOB (COMINIT/COMRESET/COMWAKE) detector.
package oob_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_BURST_MIN    = 100;
  localparam int DEF_BURST_MAX    = 220;
  localparam int DEF_WAKE_GAP_MIN = 100;
  localparam int DEF_WAKE_GAP_MAX = 220;
  localparam int DEF_INIT_GAP_MIN = 400;
  localparam int DEF_INIT_GAP_MAX = 560;
  localparam int DEF_N_BURSTS     = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_GAP,
    S_LONG
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    WAKE,
    INIT,
    BAD
  } gap_t;

  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/oob_sat_counter.sv
// Load/increment counter that sticks at all-ones instead of wrapping.
module oob_sat_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == {W{1'b1}}) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst)       count <= '0;
    else if (load) count <= load_val;
    else if (inc)  count <= sat_inc(count);
  end

endmodule

// File: rtl/oob_detect.sv
// SATA OOB burst/gap sequence detector. Define OOB_ERRCNT_EN to add the o_err_cnt error counter.
module oob_detect
  import oob_pkg::*;
#(
  parameter int BURST_MIN    = DEF_BURST_MIN,
  parameter int BURST_MAX    = DEF_BURST_MAX,
  parameter int WAKE_GAP_MIN = DEF_WAKE_GAP_MIN,
  parameter int WAKE_GAP_MAX = DEF_WAKE_GAP_MAX,
  parameter int INIT_GAP_MIN = DEF_INIT_GAP_MIN,
  parameter int INIT_GAP_MAX = DEF_INIT_GAP_MAX,
  parameter int N_BURSTS     = DEF_N_BURSTS
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_idle,
  output logic       o_cominit_det,
  output logic       o_comwake_det,
`ifdef OOB_ERRCNT_EN
  output logic [7:0] o_err_cnt,
`endif
  output logic       o_busy
);

  localparam logic [CNT_W-1:0] BMIN  = CNT_W'(BURST_MIN);
  localparam logic [CNT_W-1:0] BMAX  = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] WGMIN = CNT_W'(WAKE_GAP_MIN);
  localparam logic [CNT_W-1:0] WGMAX = CNT_W'(WAKE_GAP_MAX);
  localparam logic [CNT_W-1:0] IGMIN = CNT_W'(INIT_GAP_MIN);
  localparam logic [CNT_W-1:0] IGMAX = CNT_W'(INIT_GAP_MAX);
  localparam logic [7:0]       NB    = 8'(N_BURSTS);

  state_t           state;
  gap_t             seq_type;
  gap_t             cur_gap;
  gap_t             gap_class;
  logic [7:0]       seq_cnt;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic             burst_ok;
  logic             burst_load, burst_inc, gap_load, gap_inc;
  logic             cominit_det, comwake_det;

  function automatic gap_t classify(input logic [CNT_W-1:0] len);
    if (in_window(len, WGMIN, WGMAX)) return WAKE;
    if (in_window(len, IGMIN, IGMAX)) return INIT;
    return BAD;
  endfunction

  assign gap_class  = classify(gap_cnt);
  assign burst_ok   = in_window(burst_cnt, BMIN, BMAX);
  assign burst_load = ((state == S_IDLE) || (state == S_GAP)) && !i_rx_idle;
  assign burst_inc  = ((state == S_BURST) || (state == S_LONG)) && !i_rx_idle;
  assign gap_load   = ((state == S_BURST) || (state == S_LONG)) && i_rx_idle;
  assign gap_inc    = (state == S_GAP) && i_rx_idle;

  oob_sat_counter #(.W(CNT_W)) u_burst_cnt (
    .clk(i_clk), .rst(i_rst), .load(burst_load), .inc(burst_inc),
    .load_val(CNT_W'(1)), .count(burst_cnt)
  );

  oob_sat_counter #(.W(CNT_W)) u_gap_cnt (
    .clk(i_clk), .rst(i_rst), .load(gap_load), .inc(gap_inc),
    .load_val(CNT_W'(1)), .count(gap_cnt)
  );

  // cur_gap holds the class of the gap that preceded the burst in progress
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      seq_cnt     <= '0;
      seq_type    <= NONE;
      cur_gap     <= NONE;
      cominit_det <= 1'b0;
      comwake_det <= 1'b0;
    end else begin
      cominit_det <= 1'b0;
      comwake_det <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!i_rx_idle) begin
            state   <= S_BURST;
            cur_gap <= NONE;
          end
        end
        S_BURST: begin
          if (i_rx_idle) begin
            state <= S_GAP;
            if (!burst_ok) begin
              seq_cnt <= '0;
            end else if (seq_cnt == 8'd0) begin
              seq_cnt  <= 8'd1;
              seq_type <= NONE;
            end else if ((seq_type == NONE) || (seq_type == cur_gap)) begin
              if (seq_cnt + 8'd1 == NB) begin
                seq_cnt     <= '0;
                cominit_det <= (cur_gap == INIT);
                comwake_det <= (cur_gap == WAKE);
              end else begin
                seq_cnt  <= seq_cnt + 8'd1;
                seq_type <= cur_gap;
              end
            end else begin
              seq_cnt  <= 8'd1;
              seq_type <= cur_gap;
            end
          end else if (burst_cnt == BMAX) begin
            state   <= S_LONG;
            seq_cnt <= '0;
          end
        end
        S_LONG: begin
          if (i_rx_idle) begin
            state   <= S_GAP;
            seq_cnt <= '0;
          end
        end
        S_GAP: begin
          if (!i_rx_idle) begin
            state   <= S_BURST;
            cur_gap <= gap_class;
            if (gap_class == BAD) seq_cnt <= '0;
          end else if (gap_cnt == IGMAX) begin
            state   <= S_IDLE;
            seq_cnt <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_cominit_det = cominit_det;
  assign o_comwake_det = comwake_det;
  assign o_busy        = (state != S_IDLE);

`ifdef OOB_ERRCNT_EN
  logic       err_inc;
  logic [7:0] err_cnt;

  assign err_inc = ((state == S_BURST) && i_rx_idle && !burst_ok) ||
                   ((state == S_BURST) && !i_rx_idle && (burst_cnt == BMAX)) ||
                   ((state == S_GAP) && !i_rx_idle && (gap_class == BAD));

  always_ff @(posedge i_clk) begin
    if (i_rst)                           err_cnt <= '0;
    else if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end

  assign o_err_cnt = err_cnt;
`endif

endmodule

// File: tb/tb_oob_detect.sv
// Directed-vector bench for oob_detect; build with OOB_ERRCNT_EN to also exercise o_err_cnt.
module tb_oob_detect;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_idle = 1'b1;
  logic cominit_det, comwake_det, busy;
`ifdef OOB_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_init = 0;
  int n_wake = 0;
  int n_both = 0;

  always #5 clk = ~clk;

  oob_detect dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx_idle(rx_idle),
    .o_cominit_det(cominit_det),
    .o_comwake_det(comwake_det),
`ifdef OOB_ERRCNT_EN
    .o_err_cnt(err_cnt),
`endif
    .o_busy(busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hold the line at lvl for n clocks, sampling outputs 1ns after each edge.
  task automatic cycles(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      rx_idle = lvl;
      @(posedge clk);
      #1;
      if (cominit_det) n_init++;
      if (comwake_det) n_wake++;
      if (cominit_det && comwake_det) n_both++;
    end
  endtask

  task automatic bursts(input int nb, input int blen, input int gap);
    for (int b = 0; b < nb; b++) begin
      cycles(1'b0, blen);
      if (b < nb - 1) cycles(1'b1, gap);
    end
  endtask

  task automatic do_reset;
    rx_idle = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_init = 0;
    n_wake = 0;
  endtask

  task automatic check_err(input string tag, input int exp);
`ifdef OOB_ERRCNT_EN
    check(tag, int'(err_cnt), exp);
`endif
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_busy", int'(busy), 0);
    check("rst_init", int'(cominit_det), 0);
    check("rst_wake", int'(comwake_det), 0);
    check_err("rst_err", 0);

    // COMINIT: 4 x 160 with 480 gaps
    do_reset();
    bursts(4, 160, 480);
    check("init_early", int'(cominit_det), 0);
    cycles(1'b1, 1);
    check("init_pulse", int'(cominit_det), 1);
    check("init_wake_lo", int'(comwake_det), 0);
    check("init_busy", int'(busy), 1);
    cycles(1'b1, 1);
    check("init_one_cyc", int'(cominit_det), 0);
    check("init_cnt", n_init, 1);
    check("init_wake_cnt", n_wake, 0);
    // gap 560 is still a gap, 561 times out
    cycles(1'b1, 558);
    check("gap560_busy", int'(busy), 1);
    cycles(1'b1, 1);
    check("gap561_idle", int'(busy), 0);

    // COMWAKE: 6 x 160 with 160 gaps, only one pulse
    do_reset();
    bursts(4, 160, 160);
    cycles(1'b1, 1);
    check("wake_pulse", int'(comwake_det), 1);
    check("wake_init_lo", int'(cominit_det), 0);
    cycles(1'b1, 159);
    bursts(2, 160, 160);
    cycles(1'b1, 300);
    check("wake_cnt", n_wake, 1);
    check("wake_init_cnt", n_init, 0);

    // type change INIT -> WAKE restarts the count
    do_reset();
    cycles(1'b0, 160); cycles(1'b1, 480);
    cycles(1'b0, 160); cycles(1'b1, 160);
    cycles(1'b0, 160); cycles(1'b1, 160);
    cycles(1'b0, 160); cycles(1'b1, 20);
    check("mix_init", n_init, 0);
    check("mix_wake", n_wake, 0);

    // continuous activity -> S_LONG
    do_reset();
    cycles(1'b0, 1000);
    check("long_busy", int'(busy), 1);
    cycles(1'b1, 600);
    check("long_pulses", n_init + n_wake, 0);
    check("long_idle", int'(busy), 0);
    check_err("long_err", 1);

    // 300-cycle BAD gap inside a sequence
    do_reset();
    cycles(1'b0, 160); cycles(1'b1, 480);
    cycles(1'b0, 160); cycles(1'b1, 300);
    cycles(1'b0, 160); cycles(1'b1, 480);
    cycles(1'b0, 160); cycles(1'b1, 600);
    check("bad_pulses", n_init + n_wake, 0);
    check("bad_idle", int'(busy), 0);
    check_err("bad_err", 1);

    // reset during the 4th burst
    do_reset();
    bursts(3, 160, 480);
    cycles(1'b1, 480);
    cycles(1'b0, 100);
    rst = 1'b1;
    cycles(1'b0, 1);
    rst = 1'b0;
    check("rst4_busy", int'(busy), 0);
    check("rst4_init", int'(cominit_det), 0);
    check("rst4_wake", int'(comwake_det), 0);
    check_err("rst4_err", 0);
    cycles(1'b0, 60);
    cycles(1'b1, 10);
    check("rst4_pulses", n_init + n_wake, 0);

    // burst and WAKE gap window edges: 100/220 bursts, 100/220 gaps
    do_reset();
    cycles(1'b0, 100); cycles(1'b1, 100);
    cycles(1'b0, 220); cycles(1'b1, 220);
    cycles(1'b0, 100); cycles(1'b1, 100);
    cycles(1'b0, 220); cycles(1'b1, 1);
    check("edge_wake_pulse", int'(comwake_det), 1);
    cycles(1'b1, 10);
    check("edge_wake_cnt", n_wake, 1);

    // INIT gap window edges 400/560, last burst 99 is too short
    do_reset();
    cycles(1'b0, 160); cycles(1'b1, 400);
    cycles(1'b0, 160); cycles(1'b1, 560);
    cycles(1'b0, 160); cycles(1'b1, 400);
    cycles(1'b0, 99);  cycles(1'b1, 10);
    check("short_pulses", n_init + n_wake, 0);
    check_err("short_err", 1);

    do_reset();
    cycles(1'b0, 160); cycles(1'b1, 400);
    cycles(1'b0, 160); cycles(1'b1, 560);
    cycles(1'b0, 160); cycles(1'b1, 400);
    cycles(1'b0, 160); cycles(1'b1, 1);
    check("edge_init_pulse", int'(cominit_det), 1);
    cycles(1'b1, 10);
    check("edge_init_cnt", n_init, 1);

    // 221-cycle burst counts as activity, not OOB
    do_reset();
    bursts(3, 160, 160);
    cycles(1'b1, 160);
    cycles(1'b0, 221);
    cycles(1'b1, 10);
    check("b221_pulses", n_init + n_wake, 0);
    check_err("b221_err", 1);

    check("never_both", n_both, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
